imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side companion to the instruction memory: receives a byte stream (e.g. from a UART receiver), assembles little-endian 32-bit words and drives the memory's write port.
- Holds the core in reset until the whole program image is written.
- Sits between the serial front end and the instruction memory write port. Replaces $readmemh preloading on hardware.

Parameters:
- n, 32, instruction/data word width in bits (fixed 32; bytes per word = n/8 = 4)
- DEPTH, 1024, instruction memory depth in words (4 KB); maximum loadable word count

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  single-cycle pulse; restarts a load from DONE or ERR, ignored in other states
- byte_valid  input  1  byte_data is valid this cycle
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction memory write enable, one cycle per word
- mem_addr  output  n  byte address of the word written; word index in bits [11:2], bits [1:0] = 0
- mem_wdata  output  n  assembled word
- load_done  output  1  image fully written
- load_err  output  1  header word count exceeded DEPTH
- cpu_rst_n  output  1  active-low reset to the core; low until load_done

Behaviour:
- Handshake: a byte transfers on a rising edge where byte_valid && byte_ready. byte_data is sampled only on that edge.
- Stream format:
  - 2-byte header: word count N, little-endian (low byte first).
  - Then N*4 payload bytes. Within each word, the first byte goes to [7:0] and the fourth byte to [31:24].
- FSM states: LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
- Reset (rst_n=0 at an edge): state=LEN_LO, word index=0, byte counter=0, N=0, mem_we=0, mem_addr=0, mem_wdata=0, load_done=0, load_err=0, cpu_rst_n=0.
  - Reset mid-load abandons the load immediately. Words already written stay in memory.
- byte_ready=1 in LEN_LO, LEN_HI and DATA. byte_ready=0 in WRITE, DONE and ERR.
- LEN_LO: on accept, latch N[7:0] and go to LEN_HI.
- LEN_HI: on accept, latch N[15:8], then:
  - full 16-bit N == 0 -> DONE
  - N > DEPTH -> ERR
  - otherwise -> DATA
- DATA: on each accept, shift the byte into its lane and increment the 2-bit byte counter. The accept of the 4th byte moves to WRITE.
- WRITE: exactly one cycle.
  - Outputs: mem_we=1, mem_addr = word_index*4, mem_wdata = assembled word.
  - At the end of the cycle, word_index increments. If the new index == N go to DONE, else DATA. The byte counter is 0 on entering DATA.
  - Write latency: mem_we asserts in the cycle after the clock edge that accepted the 4th byte.
- mem_we is 0 in all states other than WRITE. mem_addr and mem_wdata are registered and hold their last values outside WRITE.
- DONE: load_done=1, cpu_rst_n=1, held indefinitely.
- ERR: load_err=1, cpu_rst_n=0, held indefinitely. No memory writes are issued.
- start in DONE or ERR:
  - Next state LEN_LO; index, counters and N cleared.
  - load_done, load_err and cpu_rst_n go to 0 in the next cycle.
  - start is ignored in all other states.
- Boundaries:
  - N == DEPTH is legal. The last write is to address 0xFFC; the index does not wrap.
  - byte_valid held high while in WRITE causes no accept and no byte loss; the upstream source holds the byte until it is accepted.
  - Bytes arriving in DONE or ERR are not accepted (byte_ready=0).
- Width rules:
  - word_index is 11 bits wide, so it can hold the value DEPTH.
  - The N comparison uses the full 16 bits.
  - mem_addr = {word_index[9:0], 2'b00}, zero-extended to n.

Decomposition:
- Shared package, used by both the loader and the bench:
  - state enum localparams (LEN_LO..ERR)
  - IMEM_DEPTH = 1024
  - IMEM_ADDR_LSB = 2
  - IMEM_ADDR_MSB = 11
- No sub-module: word assembly is a 32-bit shift register inside the FSM module.
- The instruction memory gains a synchronous write port (we, addr, wdata) driven by this block. That is a change to the memory module, not part of this block.

Test Plan:
- Reset, then stream 02 00 | 13 00 00 00 | 93 00 10 00:
  - mem_we pulses twice: addr 0x000 / data 0x00000013, then addr 0x004 / data 0x00100093.
  - load_done=1 and cpu_rst_n=1 on the cycle after the second WRITE.
- Header 00 00 -> DONE immediately after the 2nd byte; no mem_we; byte_ready=0 afterwards.
- Header 01 04 (N=1025) -> load_err=1, cpu_rst_n=0, no writes. Then a start pulse -> LEN_LO with load_err=0 on the next cycle.
- N=1024 (header 00 04), payload word k = k:
  - 1024 writes, the last at addr 0xFFC with data 0x000003FF.
  - load_done=1; a 4 KB read-back through the memory's read port matches.
- byte_valid held continuously (back-to-back bytes):
  - byte_ready drops for exactly one cycle after every 4th payload byte.
  - No byte is dropped or duplicated; word contents are exact.
- rst_n low for one cycle after 6 of 8 payload bytes:
  - Outputs return to reset values; the first word stays written.
  - A fresh stream 01 00 AA BB CC DD writes 0xDDCCBBAA to addr 0x000.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states and memory geometry for the instruction memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam int IMEM_DEPTH    = 1024;
    localparam int IMEM_ADDR_LSB = 2;
    localparam int IMEM_ADDR_MSB = 11;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte stream to instruction memory writer, holds core in reset until loaded
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int n     = 32,
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         byte_valid,
    input  logic [7:0]   byte_data,
    output logic         byte_ready,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    output logic         load_done,
    output logic         load_err,
    output logic         cpu_rst_n
);

    localparam logic [15:0] DEPTH_W = DEPTH[15:0];

    state_t         r_state;
    state_t         w_next;
    logic [10:0]    r_word_idx;
    logic [1:0]     r_byte_cnt;
    logic [15:0]    r_len;
    logic [n-1:0]   r_shift;
    logic [n-1:0]   r_mem_addr;
    logic [n-1:0]   r_mem_wdata;

    logic           w_byte_ready;
    logic           w_mem_we;
    logic           w_done;
    logic           w_err;
    logic           w_cpu_rst_n;
    logic           w_accept;
    logic [15:0]    w_len_full;
    logic [10:0]    w_idx_inc;
    logic [n-1:0]   w_shift_next;
    logic [n-1:0]   w_addr;

    assign w_accept     = byte_valid & w_byte_ready;
    // The high header byte is still on the bus when the length decision is made.
    assign w_len_full   = {byte_data, r_len[7:0]};
    assign w_idx_inc    = r_word_idx + 11'd1;
    // Bytes enter at the top, so after four accepts the first byte sits in [7:0].
    assign w_shift_next = {byte_data, r_shift[n-1:8]};

    // Byte address of the current word: index in [11:2], everything else zero.
    always_comb begin
        w_addr = '0;
        w_addr[IMEM_ADDR_MSB:IMEM_ADDR_LSB] = r_word_idx[IMEM_ADDR_MSB-IMEM_ADDR_LSB:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LEN_LO;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_next       = r_state;
        w_byte_ready = 1'b0;
        w_mem_we     = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_cpu_rst_n  = 1'b0;
        case (r_state)
            LEN_LO: begin
                w_byte_ready = 1'b1;
                if (byte_valid) w_next = LEN_HI;
            end
            LEN_HI: begin
                w_byte_ready = 1'b1;
                if (byte_valid) begin
                    if (w_len_full == 16'd0)         w_next = DONE;
                    else if (w_len_full > DEPTH_W)   w_next = ERR;
                    else                             w_next = DATA;
                end
            end
            DATA: begin
                w_byte_ready = 1'b1;
                if (byte_valid && r_byte_cnt == 2'd3) w_next = WRITE;
            end
            WRITE: begin
                w_mem_we = 1'b1;
                if ({5'd0, w_idx_inc} == r_len) w_next = DONE;
                else                            w_next = DATA;
            end
            DONE: begin
                w_done      = 1'b1;
                w_cpu_rst_n = 1'b1;
                if (start) w_next = LEN_LO;
            end
            ERR: begin
                w_err = 1'b1;
                if (start) w_next = LEN_LO;
            end
            default: w_next = LEN_LO;
        endcase
    end

    // Header capture, word assembly, write-port registers and word index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word_idx  <= '0;
            r_byte_cnt  <= '0;
            r_len       <= '0;
            r_shift     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                LEN_LO: if (w_accept) r_len[7:0]  <= byte_data;
                LEN_HI: if (w_accept) r_len[15:8] <= byte_data;
                DATA: begin
                    if (w_accept) begin
                        r_shift    <= w_shift_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_addr  <= w_addr;
                            r_mem_wdata <= w_shift_next;
                        end
                    end
                end
                WRITE: begin
                    r_word_idx <= w_idx_inc;
                    r_byte_cnt <= '0;
                end
                DONE, ERR: begin
                    if (start) begin
                        r_word_idx <= '0;
                        r_byte_cnt <= '0;
                        r_len      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_ready = w_byte_ready;
    assign mem_we     = w_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign load_done  = w_done;
    assign load_err   = w_err;
    assign cpu_rst_n  = w_cpu_rst_n;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for the instruction memory loader
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        load_done;
    logic        load_err;
    logic        cpu_rst_n;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;

    logic [63:0] exp_q[$];
    logic [31:0] tb_mem [0:IMEM_DEPTH-1];

    imem_loader #(.n(32), .DEPTH(IMEM_DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .load_done  (load_done),
        .load_err   (load_err),
        .cpu_rst_n  (cpu_rst_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Monitor: every write-port pulse is popped against the scoreboard and mirrored into a memory model.
    always @(negedge clk) begin
        logic [63:0] e;
        if (mem_we === 1'b1) begin
            n_writes++;
            tb_mem[mem_addr[11:2]] = mem_wdata;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e[63:32]);
                chk("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, output int waits);
        byte_valid = 1'b1;
        byte_data  = b;
        waits      = 0;
        while (byte_ready !== 1'b1 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (byte_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h not accepted, expected acceptance", b);
        end
        @(negedge clk);
    endtask

    task automatic send_stream(input logic [7:0] bs[$], input bit gap);
        int w;
        foreach (bs[i]) begin
            send_byte(bs[i], w);
            if (gap) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d pending writes, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bs[$];
        int w;
        int w0;
        int exp_w;
        logic [7:0] b5[12];

        for (int i = 0; i < IMEM_DEPTH; i++) tb_mem[i] = 32'h0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_load_err", {31'd0, load_err}, 32'd0);
        chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd1);
        rst_n = 1'b1;

        // Two-word program with idle gaps between bytes
        exp_q.push_back({32'h000, 32'h00000013});
        exp_q.push_back({32'h004, 32'h00100093});
        bs = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10};
        send_stream(bs, 1'b1);
        send_byte(8'h00, w);
        byte_valid = 1'b0;
        chk("t1_we_latency", {31'd0, mem_we}, 32'd1);
        chk("t1_ready_in_write", {31'd0, byte_ready}, 32'd0);
        chk("t1_done_not_yet", {31'd0, load_done}, 32'd0);
        @(negedge clk);
        chk("t1_load_done", {31'd0, load_done}, 32'd1);
        chk("t1_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        chk("t1_mem_we_off", {31'd0, mem_we}, 32'd0);
        chk("t1_addr_hold", mem_addr, 32'h004);
        drain("t1_drain");

        // Zero-length header
        pulse_start();
        chk("t2_done_cleared", {31'd0, load_done}, 32'd0);
        chk("t2_cpu_rst_cleared", {31'd0, cpu_rst_n}, 32'd0);
        w0 = n_writes;
        bs = '{8'h00, 8'h00};
        send_stream(bs, 1'b0);
        chk("t2_load_done", {31'd0, load_done}, 32'd1);
        chk("t2_byte_ready", {31'd0, byte_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t2_no_writes", n_writes, w0);

        // Oversized header N=1025
        pulse_start();
        w0 = n_writes;
        bs = '{8'h01, 8'h04};
        send_stream(bs, 1'b0);
        chk("t3_load_err", {31'd0, load_err}, 32'd1);
        chk("t3_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("t3_byte_ready", {31'd0, byte_ready}, 32'd0);
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        chk("t3_err_ready", {31'd0, byte_ready}, 32'd0);
        chk("t3_err_held", {31'd0, load_err}, 32'd1);
        chk("t3_no_writes", n_writes, w0);
        pulse_start();
        chk("t3_err_cleared", {31'd0, load_err}, 32'd0);
        chk("t3_ready_again", {31'd0, byte_ready}, 32'd1);

        // Full-depth image N=1024, word k = k
        bs = '{8'h00, 8'h04};
        for (int k = 0; k < IMEM_DEPTH; k++) begin
            exp_q.push_back({32'(k) << 2, 32'(k)});
            bs.push_back(8'(k));
            bs.push_back(8'(k >> 8));
            bs.push_back(8'h00);
            bs.push_back(8'h00);
        end
        send_stream(bs, 1'b0);
        chk("t4_last_addr", mem_addr, 32'hFFC);
        chk("t4_last_data", mem_wdata, 32'h000003FF);
        @(negedge clk);
        chk("t4_load_done", {31'd0, load_done}, 32'd1);
        drain("t4_drain");
        for (int k = 0; k < IMEM_DEPTH; k++) chk("t4_readback", tb_mem[k], 32'(k));

        // Back-to-back bytes: ready drops for one cycle after each completed word
        pulse_start();
        exp_q.push_back({32'h000, 32'h44332211});
        exp_q.push_back({32'h004, 32'h88776655});
        exp_q.push_back({32'h008, 32'hCCBBAA99});
        send_byte(8'h03, w);
        chk("t5_wait_hdr0", w, 0);
        send_byte(8'h00, w);
        chk("t5_wait_hdr1", w, 0);
        b5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        for (int i = 0; i < 12; i++) begin
            send_byte(b5[i], w);
            exp_w = (i > 0 && (i % 4) == 0) ? 1 : 0;
            chk("t5_wait_payload", w, exp_w);
        end
        byte_valid = 1'b0;
        @(negedge clk);
        chk("t5_load_done", {31'd0, load_done}, 32'd1);
        drain("t5_drain");

        // Reset mid-load after 6 of 8 payload bytes
        pulse_start();
        exp_q.push_back({32'h000, 32'hD4C3B2A1});
        bs = '{8'h02, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        send_stream(bs, 1'b1);
        drain("t6_drain_first");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("t6_rst_mem_addr", mem_addr, 32'd0);
        chk("t6_rst_mem_wdata", mem_wdata, 32'd0);
        chk("t6_rst_load_done", {31'd0, load_done}, 32'd0);
        chk("t6_rst_load_err", {31'd0, load_err}, 32'd0);
        chk("t6_rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("t6_rst_byte_ready", {31'd0, byte_ready}, 32'd1);
        chk("t6_first_word_kept", tb_mem[0], 32'hD4C3B2A1);
        exp_q.push_back({32'h000, 32'hDDCCBBAA});
        bs = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_stream(bs, 1'b0);
        @(negedge clk);
        chk("t6_load_done", {31'd0, load_done}, 32'd1);
        drain("t6_drain_second");
        chk("t6_new_word", tb_mem[0], 32'hDDCCBBAA);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
